pwm_update_sched: RTL
=====================

# pwm_update_sched

Carrier-synchronous sequencer for one PWM compare channel. It decides when the channel's shadow registers (compare, dead-time A/B, logic/carrier-select) are transferred, by issuing `maskevent`. It also starts and stops the channel (`pwm_onoff`) only on carrier zero crossings, and forces an immediate stop on a fault kill. It sits between the AXI register bank and the compare/dead-time channel, with one instance per channel.

## Interface
- `PWMCOUNT_WIDTH`, package define (16): carrier/period width.
- `UPDDIV_WIDTH`, 4: width of the update-divider field.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `carrier` in `PWMCOUNT_WIDTH`: current carrier count from the selected carrier generator.
- `period` in `PWMCOUNT_WIDTH`: carrier peak value.
- `upd_mode` in `_upd_mode`: ZERO / PEAK / BOTH, the events that qualify for update.
- `upd_div` in `UPDDIV_WIDTH`: transfer allowed every `upd_div+1` qualifying events.
- `commit_req` in 1: 1-cycle strobe; the register bank holds new shadow values.
- `start_req` in 1: 1-cycle strobe; request channel start.
- `stop_req` in 1: 1-cycle strobe; request graceful stop.
- `kill` in 1: level; fault, forces the channel off.
- `pwm_onoff` out `_pwm_onoff`: channel enable to the compare block.
- `maskevent` out 1: 1-cycle shadow-transfer pulse.
- `commit_ack` out 1: 1-cycle pulse, coincident with the `maskevent` that served a commit.
- `commit_pending` out 1: a commit is waiting for a transfer slot.
- `state` out `_sched_state`: IDLE / ARMED / RUN / STOPPING.

## Operation

**Events**
- `carr_q` is a register holding the previous `carrier` value; it resets to 0.
- zero_evt = (`carrier`==0) && (`carr_q`!=0).
- peak_evt = (`carrier`==`period`) && (`carr_q`!=`period`) && (`period`!=0).
- qual_evt = the events selected by `upd_mode`.

**Commit tracking**
- `commit_req` sets `commit_pending`.
- Repeated requests while pending merge; they produce no extra ack.

**Divider**
- `div_cnt` increments on each qual_evt in RUN/STOPPING.
- At `div_cnt`==`upd_div` the cycle is a slot: `div_cnt` goes to 0, and if pending, `maskevent` and `commit_ack` pulse and pending clears.
- A slot with nothing pending still wraps `div_cnt` to 0.
- `div_cnt` clears on entry to RUN.

**FSM**
- IDLE:
  - `pwm_onoff`=OFF.
  - A commit (pending or `commit_req`) issues `maskevent` and `commit_ack` next cycle without waiting for the carrier.
  - `start_req` with `kill` low goes to ARMED.
- ARMED:
  - Waits for zero_evt, then goes to RUN.
  - On that transition `pwm_onoff` goes ON, and if pending, `maskevent` fires in the same cycle; the divider is bypassed for this first transfer.
  - `stop_req` returns to IDLE.
- RUN:
  - `stop_req` goes to STOPPING.
  - `start_req` is ignored.
- STOPPING:
  - Updates continue.
  - At the next zero_evt the FSM goes to IDLE and `pwm_onoff` goes OFF.
  - `start_req` cancels the stop and returns to RUN, with no pulse.

**Kill**
- `kill` high goes to IDLE next cycle from any state.
- `pwm_onoff` goes OFF and the divider clears.
- Pending is retained.
- `start_req` is ignored while `kill` is high.

**Simultaneous events**
- `commit_req` on a slot cycle counts as pending for that slot.
- `kill` beats `start_req` and `stop_req`.
- `stop_req` beats `start_req` in the same cycle.

## Timing
- All outputs are registered.
- Reset values:
  - `pwm_onoff`=OFF
  - `maskevent`=0
  - `commit_ack`=0
  - `commit_pending`=0
  - `state`=IDLE
  - `div_cnt`=0
  - `carr_q`=0
- Latency: the input condition in cycle T produces the output in T+1. This applies to events, kill, and IDLE commits.
- `commit_pending` rises at T+1 after `commit_req`.
- Because `carr_q` resets to 0, a carrier sitting at 0 when reset releases is not a zero_evt.
- `period`=0 disables peak_evt; zero_evt never fires, so ARMED waits until `kill` or `stop_req`.
- The divider wraps modulo `upd_div+1`; `upd_div`=0 means every qualifying event.

## Structure
- `PKG_pwm` gains:
  - `typedef enum _upd_mode` {ZERO, PEAK, BOTH}
  - `typedef enum _sched_state` {IDLE, ARMED, RUN, STOPPING}
  - `UPDDIV_WIDTH` define
- Sub-module `carrier_event_detect`: holds `carr_q` and produces zero_evt/peak_evt. It is reused by other channels.
- The FSM, divider and commit tracking live in `pwm_update_sched`.

## Test plan
1. Reset, `period`=100, carrier up-counting 0..99; `start_req` at carrier=40 → ARMED; `pwm_onoff`=ON exactly 1 cycle after carrier returns to 0.
2. RUN, mode ZERO, `upd_div`=2, `commit_req` at carrier=10 → `maskevent`/`commit_ack` only on the 3rd zero crossing counted from RUN entry; three back-to-back `commit_req` → one ack.
3. Mode BOTH, `upd_div`=0, up/down carrier 0↔100, commit each half period → `maskevent` at both the 100 and 0 crossings, one cycle late.
4. `stop_req` at carrier=30 → STOPPING; `pwm_onoff` OFF 1 cycle after next zero; `start_req` during STOPPING → RUN, no OFF.
5. `kill` mid-period with commit pending → IDLE and OFF next cycle, pending stays 1; release `kill`, no start → commit transfers in IDLE next cycle.
6. `commit_req` coincident with a slot-cycle zero_evt → `maskevent` next cycle; reset asserted mid-STOPPING → all outputs at reset values next cycle.

Source files
------------

// File: rtl/pwm_update_sched_pkg.sv
// Shared types and widths for the PWM channel update scheduler and its
// carrier event detector.
package pwm_update_sched_pkg;

  // Carrier / period counter width
  localparam int PWMCOUNT_WIDTH = 16;

  // Width of the update-divider field (transfer every upd_div+1 events)
  localparam int UPDDIV_WIDTH = 4;

  // Carrier events that qualify for a shadow transfer
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    PEAK = 2'd1,
    BOTH = 2'd2
  } _upd_mode;

  // Channel sequencing state
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } _sched_state;

  // Channel enable towards the compare block
  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } _pwm_onoff;

  // Select the qualifying event for the current update mode.
  // An unused encoding qualifies nothing, so a misprogrammed mode freezes
  // transfers instead of firing on every cycle.
  function automatic logic qual_event(input _upd_mode mode,
                                      input logic     zero_evt,
                                      input logic     peak_evt);
    logic q;
    case (mode)
      ZERO:    q = zero_evt;
      PEAK:    q = peak_evt;
      BOTH:    q = zero_evt | peak_evt;
      default: q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/carrier_event_detect.sv
// Carrier zero / peak crossing detector. Remembers the previous carrier
// sample so that a carrier parked at 0 or at the peak produces a single
// event on arrival rather than one per cycle. Shared by all channels.
module carrier_event_detect
  import pwm_update_sched_pkg::*;
#(
  parameter int WIDTH = PWMCOUNT_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] carrier_i,
  input  logic [WIDTH-1:0] period_i,
  output logic             zero_evt_o,
  output logic             peak_evt_o
);

  logic [WIDTH-1:0] carr_q;

  // Previous carrier sample; cleared on reset so a carrier already sitting
  // at 0 when reset releases is not mistaken for a fresh zero crossing.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      carr_q <= '0;
    end else begin
      carr_q <= carrier_i;
    end
  end

  // Edge-style event decode; a zero period disables the peak event because
  // zero and peak would otherwise coincide.
  always_comb begin
    zero_evt_o = (carrier_i == '0) && (carr_q != '0);
    peak_evt_o = (carrier_i == period_i) && (carr_q != period_i) &&
                 (period_i != '0);
  end

endmodule

// File: rtl/pwm_update_sched.sv
// Carrier-synchronous sequencer for one PWM compare channel.
// Issues maskevent to transfer shadow registers on divided carrier events,
// starts/stops the channel only at carrier zero crossings and drops the
// channel immediately on a kill. All outputs are registered.
module pwm_update_sched
  import pwm_update_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PWMCOUNT_WIDTH-1:0] carrier,
  input  logic [PWMCOUNT_WIDTH-1:0] period,
  input  _upd_mode                  upd_mode,
  input  logic [UPDDIV_WIDTH-1:0]   upd_div,
  input  logic                      commit_req,
  input  logic                      start_req,
  input  logic                      stop_req,
  input  logic                      kill,
  output _pwm_onoff                 pwm_onoff,
  output logic                      maskevent,
  output logic                      commit_ack,
  output logic                      commit_pending,
  output _sched_state               state
);

  logic                    zero_evt;
  logic                    peak_evt;

  _sched_state             state_q;
  _pwm_onoff               onoff_q;
  logic                    maskevent_q;
  logic                    ack_q;
  logic                    pending_q;
  logic [UPDDIV_WIDTH-1:0] div_cnt_q;

  logic                    qual_d;
  logic                    pend_d;
  logic                    counting_d;
  logic                    slot_d;
  logic [UPDDIV_WIDTH-1:0] div_cnt_d;

  carrier_event_detect #(
    .WIDTH (PWMCOUNT_WIDTH)
  ) u_evt (
    .clk_i      (clk),
    .reset_i    (reset),
    .carrier_i  (carrier),
    .period_i   (period),
    .zero_evt_o (zero_evt),
    .peak_evt_o (peak_evt)
  );

  // Qualifying event, effective pending (a commit arriving on a slot cycle
  // is served by that slot), and the divider slot/next-count decode.
  // The slot compares with >= so that lowering upd_div below the running
  // count wraps at the next event instead of counting all the way round.
  always_comb begin
    qual_d     = qual_event(upd_mode, zero_evt, peak_evt);
    pend_d     = pending_q | commit_req;
    counting_d = (state_q == RUN) || (state_q == STOPPING);
    slot_d     = counting_d && qual_d && (div_cnt_q >= upd_div);
    div_cnt_d  = div_cnt_q;
    if (counting_d && qual_d) begin
      div_cnt_d = slot_d ? '0 : div_cnt_q + 1'b1;
    end
  end

  // Sequencer FSM with divider and commit tracking; every output is a
  // register updated here. Kill overrides all state-specific behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      onoff_q     <= OFF;
      maskevent_q <= 1'b0;
      ack_q       <= 1'b0;
      pending_q   <= 1'b0;
      div_cnt_q   <= '0;
    end else begin
      maskevent_q <= 1'b0;
      ack_q       <= 1'b0;
      if (kill) begin
        // Fault: drop the channel now but keep any commit for later.
        state_q   <= IDLE;
        onoff_q   <= OFF;
        div_cnt_q <= '0;
        pending_q <= pend_d;
      end else begin
        case (state_q)
          IDLE: begin
            // Channel stopped: commits transfer straight away.
            onoff_q     <= OFF;
            div_cnt_q   <= '0;
            maskevent_q <= pend_d;
            ack_q       <= pend_d;
            pending_q   <= 1'b0;
            if (start_req && !stop_req) begin
              state_q <= ARMED;
            end
          end
          ARMED: begin
            div_cnt_q <= '0;
            pending_q <= pend_d;
            if (stop_req) begin
              state_q <= IDLE;
            end else if (zero_evt) begin
              // First transfer rides on the start edge, divider bypassed.
              state_q     <= RUN;
              onoff_q     <= ON;
              maskevent_q <= pend_d;
              ack_q       <= pend_d;
              pending_q   <= 1'b0;
            end
          end
          RUN, STOPPING: begin
            div_cnt_q   <= div_cnt_d;
            maskevent_q <= slot_d && pend_d;
            ack_q       <= slot_d && pend_d;
            pending_q   <= pend_d && !slot_d;
            if (state_q == RUN) begin
              if (stop_req) begin
                state_q <= STOPPING;
              end
            end else if (zero_evt) begin
              // Graceful stop completes on the zero crossing.
              state_q <= IDLE;
              onoff_q <= OFF;
            end else if (start_req && !stop_req) begin
              // Stop cancelled: resume with a fresh divider phase.
              state_q   <= RUN;
              div_cnt_q <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            onoff_q <= OFF;
          end
        endcase
      end
    end
  end

  assign pwm_onoff      = onoff_q;
  assign maskevent      = maskevent_q;
  assign commit_ack     = ack_q;
  assign commit_pending = pending_q;
  assign state          = state_q;

endmodule
